// File: rtl/var_delay_pkg.sv
// -----------------------------------------------------------------------------
// var_delay_pkg
//   Shared types and helpers for the runtime-programmable delay line.
//   - state_e     : controller state (RUN = normal replay, FILL = refilling
//                   after a delay change, output masked)
//   - clamp_delay : folds a requested delay into the legal range 1..max_d
// -----------------------------------------------------------------------------
package var_delay_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    FILL = 1'b1
  } state_e;

  // A zero delay cannot be honoured by a read-before-write ring, so it becomes 1;
  // anything beyond the ring depth saturates at the depth.
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_d);
    int unsigned res;
    if (req == 32'd0) begin
      res = 32'd1;
    end else if (req > max_d) begin
      res = max_d;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/var_delay_ctrl.sv
// -----------------------------------------------------------------------------
// var_delay_ctrl
//   Runtime-programmable delay line. Replays the in_data/in_valid stream exactly
//   cur_delay cycles later using a MAX_DELAY-deep ring buffer. The delay is
//   changed through a valid/ready handshake; after a change the output is
//   masked (FILL) for exactly the new delay so that only samples written under
//   the new setting are ever presented.
//
// Ports
//   clk        in   1     clock, all logic on posedge
//   rst        in   1     asynchronous active-high reset
//   in_data    in   BITS  sample written every cycle
//   in_valid   in   1     qualifier stored alongside in_data
//   cfg_delay  in   DW    requested delay in cycles
//   cfg_valid  in   1     config request
//   cfg_ready  out  1     config accepted when cfg_valid & cfg_ready
//   out_data   out  BITS  in_data from cur_delay cycles ago; 0 when out_valid=0
//   out_valid  out  1     in_valid from cur_delay cycles ago, masked during FILL
//   cur_delay  out  DW    delay currently in force
//   busy       out  1     1 while refilling after a delay change
// -----------------------------------------------------------------------------
module var_delay_ctrl
  import var_delay_pkg::*;
#(
  parameter int BITS          = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 4,
  // Derived width of cfg_delay/cur_delay; not meant to be overridden.
  parameter int DW            = $clog2(MAX_DELAY + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  input  logic [DW-1:0]   cfg_delay,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  output logic [DW-1:0]   cur_delay,
  output logic            busy
);

  // Ring index width and the one-bit-wider width used for wrap arithmetic.
  localparam int IW = $clog2(MAX_DELAY);
  localparam int AW = DW + 1;

  logic [BITS-1:0]      r_mem [MAX_DELAY];
  logic [MAX_DELAY-1:0] r_vbit;
  logic [IW-1:0]        r_wr_ptr;
  logic [DW-1:0]        r_cur_delay;
  logic [DW-1:0]        r_fill_cnt;
  state_e               r_state;

  logic [IW-1:0]        w_wr_ptr_nxt;
  logic [AW-1:0]        w_rd_sum;
  logic [IW-1:0]        w_rd_idx;
  logic [DW-1:0]        w_clamped;
  state_e               w_state_nxt;
  logic [DW-1:0]        w_cur_delay_nxt;
  logic [DW-1:0]        w_fill_cnt_nxt;
  logic                 w_out_valid;

  assign w_clamped = DW'(clamp_delay(32'(cfg_delay), MAX_DELAY));

  // Write pointer advance with wrap at the ring depth (depth need not be 2^n).
  always_comb begin
    if (r_wr_ptr == IW'(MAX_DELAY - 1)) begin
      w_wr_ptr_nxt = {IW{1'b0}};
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + IW'(1);
    end
  end

  // Read index = (wr_ptr - cur_delay) mod MAX_DELAY, computed one bit wider so
  // the subtraction never underflows, then folded back into the ring range.
  // With cur_delay == MAX_DELAY this lands on the slot about to be overwritten,
  // which still holds the sample from MAX_DELAY cycles ago.
  always_comb begin
    w_rd_sum = AW'(r_wr_ptr) + AW'(MAX_DELAY) - AW'(r_cur_delay);
    if (w_rd_sum >= AW'(MAX_DELAY)) begin
      w_rd_idx = IW'(w_rd_sum - AW'(MAX_DELAY));
    end else begin
      w_rd_idx = IW'(w_rd_sum);
    end
  end

  // Ring data storage: written every cycle, needs no reset because every
  // read is qualified by the (reset) valid flags.
  always_ff @(posedge clk) begin
    r_mem[r_wr_ptr] <= in_data;
  end

  // Ring valid flags and write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vbit   <= {MAX_DELAY{1'b0}};
      r_wr_ptr <= {IW{1'b0}};
    end else begin
      r_vbit[r_wr_ptr] <= in_valid;
      r_wr_ptr         <= w_wr_ptr_nxt;
    end
  end

  // Reconfiguration FSM next-state logic. An accepted request always goes
  // through FILL, even when the delay is unchanged, so timing is uniform.
  // fill_cnt is loaded with delay-1, giving exactly 'delay' masked cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_delay_nxt = r_cur_delay;
    w_fill_cnt_nxt  = r_fill_cnt;
    case (r_state)
      RUN: begin
        if (cfg_valid) begin
          w_state_nxt     = FILL;
          w_cur_delay_nxt = w_clamped;
          w_fill_cnt_nxt  = w_clamped - DW'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
      FILL: begin
        if (r_fill_cnt == {DW{1'b0}}) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt    = FILL;
          w_fill_cnt_nxt = r_fill_cnt - DW'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Reconfiguration FSM state, delay in force and refill counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_cur_delay <= DW'(DEFAULT_DELAY);
      r_fill_cnt  <= {DW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_cur_delay <= w_cur_delay_nxt;
      r_fill_cnt  <= w_fill_cnt_nxt;
    end
  end

  // Output stage: decoded purely from registered state so an async reset
  // forces reset values in the same cycle; data is zeroed whenever invalid.
  always_comb begin
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    w_out_valid = 1'b0;
    if (r_state == RUN) begin
      cfg_ready   = 1'b1;
      w_out_valid = r_vbit[w_rd_idx];
    end else begin
      busy = 1'b1;
    end
    out_valid = w_out_valid;
    if (w_out_valid) begin
      out_data = r_mem[w_rd_idx];
    end else begin
      out_data = {BITS{1'b0}};
    end
  end

  assign cur_delay = r_cur_delay;

endmodule

// File: tb/tb_var_delay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_var_delay_ctrl
//   Directed + randomized bench for var_delay_ctrl. A reference model keeps the
//   full input history since reset and the delay/mask window from the accepted
//   configuration requests; every cycle the DUT outputs are compared with the
//   sample from 'delay' cycles earlier (or zeros while masked).
// -----------------------------------------------------------------------------
module tb_var_delay_ctrl;

  localparam int BITS = 8;
  localparam int MAXD = 16;
  localparam int DEFD = 4;
  localparam int DW   = $clog2(MAXD + 1);
  localparam int HIST = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic [BITS-1:0] in_data;
  logic            in_valid;
  logic [DW-1:0]   cfg_delay;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic [DW-1:0]   cur_delay;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int              t;          // cycle index since reset release
  int              md;         // delay in force
  int              fill_end;   // last masked cycle
  logic [BITS-1:0] hd [HIST];
  logic            hv [HIST];

  var_delay_ctrl #(
    .BITS(BITS), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .cfg_delay(cfg_delay), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .out_data(out_data), .out_valid(out_valid),
    .cur_delay(cur_delay), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    md       = DEFD;
    fill_end = -1;
  endtask

  task automatic check_outputs();
    logic            e_busy;
    logic            e_v;
    logic [BITS-1:0] e_d;
    int              idx;
    e_busy = (t <= fill_end);
    e_v    = 1'b0;
    e_d    = '0;
    idx    = t - md;
    if (!e_busy && idx >= 0) begin
      if (hv[idx]) begin
        e_v = 1'b1;
        e_d = hd[idx];
      end
    end
    chk("out_valid", 32'(out_valid), 32'(e_v));
    chk("out_data",  32'(out_data),  32'(e_d));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("cfg_ready", 32'(cfg_ready), 32'(!e_busy));
    chk("cur_delay", 32'(cur_delay), 32'(md));
  endtask

  // One clock cycle: check outputs, drive inputs, update model, advance.
  // Called and returns with the clock low (at a negedge).
  task automatic cyc(input logic [BITS-1:0] d, input logic v,
                     input logic cv, input logic [DW-1:0] cd);
    int req;
    check_outputs();
    in_data   = d;
    in_valid  = v;
    cfg_valid = cv;
    cfg_delay = cd;
    hd[t] = d;
    hv[t] = v;
    if (cv && !(t <= fill_end)) begin
      req      = int'(cd);
      md       = (req == 0) ? 1 : ((req > MAXD) ? MAXD : req);
      fill_end = t + md;
    end
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic rnd_cyc(input logic v_rand);
    logic v;
    v = v_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc(BITS'($urandom_range(0, 255)), v, 1'b0, '0);
  endtask

  // Wait (per the model) until the controller can accept, then request once.
  task automatic cfg(input logic [DW-1:0] d);
    for (int k = 0; k < 2 * MAXD + 2; k++) begin
      if (t > fill_end) break;
      rnd_cyc(1'b1);
    end
    cyc(BITS'($urandom_range(0, 255)), 1'b1, 1'b1, d);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    cfg_delay = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_cur_delay", 32'(cur_delay), 32'(DEFD));
    rst = 1'b0;
    model_reset();

    // 1: counting stream at the default delay
    for (int i = 0; i < 32; i++) cyc(BITS'(i), 1'b1, 1'b0, '0);

    // 2: change to 9, masked refill, then replay
    cfg(DW'(9));
    for (int i = 0; i < 20; i++) rnd_cyc(1'b1);

    // 3: clamping at both ends, wrap at full depth
    cfg(DW'(0));
    for (int i = 0; i < 10; i++) rnd_cyc(1'b1);
    cfg(DW'(31));
    for (int i = 0; i < 40; i++) rnd_cyc(1'b1);

    // 4: request held through FILL is taken only on the first RUN cycle
    cfg(DW'(5));
    for (int k = 0; k < 20; k++) begin
      logic acc;
      acc = (t > fill_end);
      cyc(BITS'($urandom_range(0, 255)), 1'b1, 1'b1, DW'(12));
      if (acc) break;
    end
    for (int i = 0; i < 20; i++) rnd_cyc(1'b1);

    // 5: alternating valid at D=3
    cfg(DW'(3));
    for (int i = 0; i < 6; i++) rnd_cyc(1'b1);
    for (int i = 0; i < 16; i++) cyc(BITS'(8'hA0 + i), 1'(i % 2 == 0), 1'b0, '0);

    // Sweep every delay with random data and random valid gaps
    for (int d = 1; d <= MAXD; d++) begin
      cfg(DW'(d));
      for (int i = 0; i < 2 * d + 4; i++) rnd_cyc(1'b1);
    end
    for (int r = 0; r < 6; r++) begin
      cfg(DW'($urandom_range(0, 31)));
      for (int i = 0; i < 24; i++) rnd_cyc(1'b1);
    end

    // 6: reset in the middle of FILL
    cfg(DW'(7));
    for (int i = 0; i < 3; i++) rnd_cyc(1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data",  32'(out_data),  32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_cur_delay", 32'(cur_delay), 32'(DEFD));
    cfg_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) cyc(BITS'(8'h40 + i), 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
